voting_machine_multi: RTL
=========================

VOTING_MACHINE_MULTI -- requirements
Module: voting_machine_multi

Interface
REQ-001 Parameter NUM_CAND, default 4, number of candidates; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, width of each per-candidate vote counter.
REQ-003 Parameter HOLD_CYC, default 10, cycles a button must be held before a vote is accepted; legal range >=1.
REQ-004 Derived constant IDX_W = clog2(NUM_CAND); derived constant TOT_W = CNT_W+IDX_W.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 mode  input  1  0 = voting, 1 = result display.
REQ-008 button  input  NUM_CAND  one bit per candidate, active-high, level.
REQ-009 sel  input  IDX_W  candidate index displayed in result mode.
REQ-010 led  output  CNT_W  registered vote count of the selected candidate.
REQ-011 total  output  TOT_W  registered sum of all accepted votes.
REQ-012 vote_ack  output  1  one-cycle pulse when a vote is counted.
REQ-013 vote_err  output  1  one-cycle pulse when a press is rejected (multi-press or saturation).
REQ-014 winner  output  IDX_W  leading candidate index (see Configuration).
REQ-015 tie  output  1  leading count shared (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, HOLD, CAST, WAIT_REL.
REQ-017 IDLE, mode=0, exactly one button bit set: capture the index, clear the hold timer, go to HOLD.
REQ-018 IDLE, mode=0, two or more bits set: pulse vote_err, go to WAIT_REL, count nothing.
REQ-019 HOLD: if button differs from the captured one-hot, return to IDLE with no vote; else increment the timer; at timer = HOLD_CYC-1 go to CAST.
REQ-020 CAST: if count[idx] < all-ones, increment it, increment total, pulse vote_ack; else leave the counters, pulse vote_err; then go to WAIT_REL.
REQ-021 WAIT_REL: stay until button = 0 is sampled, then go to IDLE; a held button SHALL produce exactly one vote.
REQ-022 mode=1 in any state: go to IDLE next cycle; a vote not yet in CAST is discarded.
REQ-023 Vote acceptance latency: vote_ack is high in the cycle after HOLD_CYC consecutive stable samples following the IDLE detection edge (first press sample + HOLD_CYC + 1 edges).
REQ-024 led SHALL equal count[sel] one cycle after mode=1/sel are sampled; led = 0 when mode=0 or sel >= NUM_CAND.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap; total cannot overflow by construction.
REQ-026 vote_ack and vote_err SHALL never be high in the same cycle.

Reset
REQ-027 reset=0 at a clock edge SHALL clear every counter, the total, the timer and the captured index, force IDLE, and drive led, total, vote_ack, vote_err, winner and tie to 0.
REQ-028 Reset asserted during HOLD or CAST SHALL abort the vote; reset has priority over all other inputs.

Configuration
REQ-029 Macro VOTING_MACHINE_WINNER_EN defined: winner = lowest index holding the maximum count, tie = 1 when two or more candidates share a non-zero maximum; both are registered and updated one cycle after any counter change.
REQ-030 Macro undefined: winner and tie ports SHALL remain present and be driven constant 0; no comparison logic is built.

Verification (NUM_CAND=4, CNT_W=8, HOLD_CYC=4)
REQ-031 Hold button=0001 for 10 cycles, release -> one vote_ack pulse; mode=1, sel=0 -> led=1, total=1.
REQ-032 button=0010 for 2 cycles, then 0 -> no vote_ack, no vote_err; count[1]=0.
REQ-033 button=0101 -> one vote_err pulse, no counter change; a later single 0100 press counts only after button=0 has been seen.
REQ-034 Preload count[3] to 255 via 255 presses, one more press -> vote_err, led stays 255 with sel=3, total=255.
REQ-035 Reset asserted in HOLD -> next cycle all outputs 0, state IDLE; the pending vote is not counted.
REQ-036 With VOTING_MACHINE_WINNER_EN: 2 votes for cand 2 and 2 for cand 1 -> winner=1, tie=1; one more for cand 2 -> winner=2, tie=0.

Source files
------------

// File: rtl/voting_machine_multi.sv
// voting_machine_multi: multi-candidate push-button voting controller.
// A single held button casts one vote after HOLD_CYC stable cycles; multi-presses
// and votes for a saturated candidate are rejected with vote_err.
// Optional feature macro: VOTING_MACHINE_WINNER_EN (registered winner/tie outputs).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a single button press in voting mode
// HOLD     | press captured, counting stable hold cycles
// CAST     | hold complete, commit vote (or reject on saturation)
// WAIT_REL | waiting for all buttons released before re-arming
module voting_machine_multi #(
    parameter  int NUM_CAND = 4,
    parameter  int CNT_W    = 8,
    parameter  int HOLD_CYC = 10,
    localparam int IDX_W    = $clog2(NUM_CAND),
    localparam int TOT_W    = CNT_W + IDX_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic [IDX_W-1:0]    sel,
    output logic [CNT_W-1:0]    led,
    output logic [TOT_W-1:0]    total,
    output logic                vote_ack,
    output logic                vote_err,
    output logic [IDX_W-1:0]    winner,
    output logic                tie
);

    localparam int TMR_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        CAST     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [TMR_W-1:0]      timer;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_enc;
    logic [NUM_CAND-1:0]   held;
    logic [CNT_W-1:0]      count [NUM_CAND];
    logic                  capture;
    logic                  timer_inc;
    logic                  cast_ok;
    logic                  err_now;

    // One-hot to index encoder for the captured press.
    always_comb begin
        idx_enc = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (button[i]) idx_enc = IDX_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        timer_inc  = 1'b0;
        cast_ok    = 1'b0;
        err_now    = 1'b0;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if ($onehot(button)) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else if (button != '0) begin
                        err_now    = 1'b1;
                        state_next = WAIT_REL;
                    end
                end
            end
            HOLD: begin
                if (mode || (button != held)) state_next = IDLE;
                else if (timer == TMR_LAST)   state_next = CAST;
                else                          timer_inc  = 1'b1;
            end
            CAST: begin
                // The vote is already committed here, so mode only affects where we go next.
                if (count[idx] != CNT_MAX) cast_ok = 1'b1;
                else                       err_now = 1'b1;
                state_next = mode ? IDLE : WAIT_REL;
            end
            WAIT_REL: begin
                if (mode || (button == '0)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture, hold timer, vote counters, total and pulse outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer    <= '0;
            idx      <= '0;
            held     <= '0;
            total    <= '0;
            vote_ack <= 1'b0;
            vote_err <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) count[i] <= '0;
        end else begin
            vote_ack <= cast_ok;
            vote_err <= err_now;
            if (capture) begin
                idx   <= idx_enc;
                held  <= button;
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + TMR_W'(1);
            end
            if (cast_ok) begin
                count[idx] <= count[idx] + CNT_W'(1);
                total      <= total + TOT_W'(1);
            end
        end
    end

    // Result display register.
    always_ff @(posedge clock) begin
        if (!reset)                            led <= '0;
        else if (mode && (int'(sel) < NUM_CAND)) led <= count[sel];
        else                                   led <= '0;
    end

`ifdef VOTING_MACHINE_WINNER_EN
    logic [CNT_W-1:0] best;
    logic [IDX_W-1:0] best_idx;
    logic [4:0]       n_at_max;

    // Find the lowest index holding the maximum and how many share it.
    always_comb begin
        best     = '0;
        best_idx = '0;
        n_at_max = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (count[i] > best) begin
                best     = count[i];
                best_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++) begin
            if (count[i] == best) n_at_max = n_at_max + 5'd1;
        end
    end

    // Register winner/tie so they follow counter changes by one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            winner <= '0;
            tie    <= 1'b0;
        end else begin
            winner <= best_idx;
            tie    <= (best != '0) && (n_at_max >= 5'd2);
        end
    end
`else
    assign winner = '0;
    assign tie    = 1'b0;
`endif

endmodule
